// File: rtl/serial_frame_checker.sv
// Serial frame receiver: start bit, DATA_BITS data bits (LSB first), parity bit, stop bit.
// Reports each frame's word, parity/framing errors and a saturating bad-frame count.
module serial_frame_checker #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     err_count
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DATA      = 3'd1;
  localparam logic [2:0] PARITY    = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam logic [4:0]       BIT_LAST = 5'(DATA_BITS - 1);
  localparam logic             ODD      = 1'(PARITY_ODD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic parity_bad(input logic running, input logic pbit);
    return ((running ^ pbit) != ODD);
  endfunction

  logic [2:0]           state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic [4:0]           bit_cnt_r;
  logic                 run_par_r;
  logic                 par_pend_r;
  logic                 frame_bad_s;
  logic                 err_inc_s;

  // Right-shifting deserialiser: newest bit enters at the MSB, so the first bit lands in bit 0.
  always_comb begin
    shift_s                = shift_r >> 1;
    shift_s[DATA_BITS-1]   = x;
  end

  // Error decision for the frame whose stop bit is being sampled this cycle.
  always_comb begin
    frame_bad_s = 1'b0;
    err_inc_s   = 1'b0;
    if (state_r == STOP) begin
      frame_bad_s = par_pend_r | ~x;
      err_inc_s   = frame_bad_s & (err_count != CNT_MAX);
    end else begin
      frame_bad_s = 1'b0;
      err_inc_s   = 1'b0;
    end
  end

  // Frame FSM with deserialiser, running parity and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      shift_r     <= {DATA_BITS{1'b0}};
      bit_cnt_r   <= 5'd0;
      run_par_r   <= 1'b0;
      par_pend_r  <= 1'b0;
      data        <= {DATA_BITS{1'b0}};
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!x) begin
            state_r   <= DATA;
            bit_cnt_r <= 5'd0;
            run_par_r <= 1'b0;
          end
        end
        DATA: begin
          shift_r   <= shift_s;
          run_par_r <= run_par_r ^ x;
          bit_cnt_r <= bit_cnt_r + 5'd1;
          if (bit_cnt_r == BIT_LAST) begin
            state_r <= PARITY;
          end
        end
        PARITY: begin
          par_pend_r <= parity_bad(run_par_r, x);
          state_r    <= STOP;
        end
        STOP: begin
          data        <= shift_r;
          parity_err  <= par_pend_r;
          framing_err <= ~x;
          valid       <= 1'b1;
          // A low stop bit may be a break; wait for the line to return high before hunting a start.
          state_r     <= x ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (x) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Saturating bad-frame counter; a clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= {CNT_W{1'b0}};
    end else if (err_clr) begin
      err_count <= {CNT_W{1'b0}};
    end else if (err_inc_s) begin
      err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_serial_frame_checker.sv
// Randomised scoreboard bench for serial_frame_checker (DATA_BITS=8, even parity, CNT_W=8).
module tb_serial_frame_checker;

  localparam int DB  = 8;
  localparam int ODD = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          x;
  logic          err_clr;
  logic [DB-1:0] data;
  logic          valid;
  logic          parity_err;
  logic          framing_err;
  logic          busy;
  logic [7:0]    err_count;

  serial_frame_checker #(.DATA_BITS(DB), .PARITY_ODD(ODD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .err_clr(err_clr),
    .data(data), .valid(valid), .parity_err(parity_err),
    .framing_err(framing_err), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic [7:0] cnt;
  } exp_t;

  exp_t expq[$];
  int   vcyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   model_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse is matched against the oldest expected frame.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && valid === 1'b1) begin
      vcyc.push_back(cyc);
      if (expq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("data", int'(data), int'(e.d));
        chk("parity_err", int'(parity_err), int'(e.pe));
        chk("framing_err", int'(framing_err), int'(e.fe));
        chk("err_count", int'(err_count), int'(e.cnt));
      end
    end
  end

  task automatic drive_bit(input logic b, input logic c);
    @(negedge clk);
    x = b;
    err_clr = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop, input logic clr);
    logic pbit;
    exp_t e;
    // correct parity bit makes total ones count match the selected parity, then optionally flip
    pbit = 1'(($countones(d) + ODD) % 2) ^ pflip;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < DB; i++) begin
      drive_bit(d[i], 1'b0);
      if (i == 0) chk("busy_in_frame", int'(busy), 1);
    end
    drive_bit(pbit, 1'b0);
    drive_bit(stop, clr);
    e.d  = d;
    e.pe = ((($countones(d) + int'(pbit)) % 2) != ODD);
    e.fe = ~stop;
    if (clr) model_cnt = 0;
    else if (e.pe || e.fe) model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
    e.cnt = 8'(model_cnt);
    expq.push_back(e);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    x = 1'b1;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err_count", int'(err_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // good frame 0xA5
    chk("idle_busy", int'(busy), 0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("after_good_busy", int'(busy), 0);

    // parity error
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    idle(3);

    // framing error followed by a break: one valid only
    n0 = vcyc.size();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) drive_bit(1'b0, 1'b0);
    chk("break_busy", int'(busy), 1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    chk("break_release_busy", int'(busy), 0);
    chk("break_valid_count", vcyc.size() - n0, 1);
    idle(2);

    // back-to-back frames
    n0 = vcyc.size();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("b2b_count", vcyc.size() - n0, 2);
    if (vcyc.size() - n0 == 2) chk("b2b_spacing", vcyc[n0+1] - vcyc[n0], DB + 3);

    // reset mid-frame
    n0 = vcyc.size();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", int'(data), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_perr", int'(parity_err), 0);
    chk("mid_rst_ferr", int'(framing_err), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_err_count", int'(err_count), 0);
    model_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    x = 1'b1;
    idle(2);
    chk("aborted_no_valid", vcyc.size() - n0, 0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    idle(3);

    // randomised frames
    for (int f = 0; f < 40; f++) begin
      logic stop;
      stop = ($urandom_range(0, 5) != 0);
      send_frame(8'($urandom), 1'($urandom_range(0, 3) == 0), stop, 1'($urandom_range(0, 9) == 0));
      if (!stop) begin
        for (int i = 0; i < int'($urandom_range(0, 5)); i++) drive_bit(1'b0, 1'b0);
        idle(1);
      end
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);

    // saturation then clear coinciding with an error frame
    for (int f = 0; f < 260; f++) send_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("sat_err_count", int'(err_count), 255);
    send_frame(8'($urandom), 1'b1, 1'b1, 1'b1);
    idle(3);
    chk("clr_err_count", int'(err_count), 0);

    for (int i = 0; i < 50 && expq.size() != 0; i++) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
